dnn_stream_host: RTL and testbench

//  Host-side end of the accelerator's src/dst word streams. Transmitter: reads
//  src_len words from a dual-port buffer memory and drives them onto the src

---
 rtl/dnn_stream_host.sv | 153 +++++++++++++++
 tb/tb_dnn_stream_host.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_stream_host.sv
// Host-side stream engine: transmits a memory buffer onto the src stream
// through a 2-entry skid FIFO and writes the received dst stream back to
// memory, one command at a time, with dst_last framing checked per command.
module dnn_stream_host #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [11:0]   src_len,
  input  logic [AW-1:0] dst_base,
  input  logic [11:0]   dst_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [DW-1:0] dst_data,
  input  logic          dst_last,
  output logic          dst_ready
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_base_q, dst_base_q;
  logic [11:0]   src_len_q, dst_len_q;
  logic [11:0]   rd_cnt_q, tx_cnt_q, rx_cnt_q;
  logic          inflight_q;
  logic [1:0]    fifo_cnt_q;
  logic [DW-1:0] fifo0_q, fifo1_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          err_q;

  logic cmd_accept, all_done, rd_room;
  logic tx_pop, fifo_pop, fifo_push, rx_acc, rx_final;

  assign cmd_accept = (state_q == IDLE) && start;
  // A read is in flight for exactly one cycle; together with the FIFO the
  // number of words owned by the transmitter never exceeds two.
  assign rd_room    = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: leave RUN once every word is moved and the last write issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (all_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: completion, busy, receive ready and read issue
  always_comb begin
    all_done  = (state_q == RUN) && (tx_cnt_q == src_len_q) &&
                (rx_cnt_q == dst_len_q) && !wr_en_q;
    busy      = (state_q == RUN);
    done      = all_done;
    dst_ready = (state_q == RUN) && (rx_cnt_q != dst_len_q);
    mem_rd_en = (state_q == RUN) && (rd_cnt_q != src_len_q) && rd_room;
  end

  // The word arriving from memory is presented directly when the FIFO is
  // empty, so the stream starts the cycle the read data becomes valid.
  assign src_valid   = (fifo_cnt_q != 2'd0) || inflight_q;
  assign src_data    = (fifo_cnt_q != 2'd0) ? fifo0_q :
                       (inflight_q ? mem_rd_data : '0);
  assign src_last    = src_valid && (tx_cnt_q == src_len_q - 12'd1);
  assign mem_rd_addr = src_base_q + AW'(rd_cnt_q);

  assign tx_pop    = src_valid && src_ready;
  assign fifo_pop  = tx_pop && (fifo_cnt_q != 2'd0);
  assign fifo_push = inflight_q && !(tx_pop && (fifo_cnt_q == 2'd0));
  assign rx_acc    = dst_valid && dst_ready;
  assign rx_final  = (rx_cnt_q == dst_len_q - 12'd1);

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign err         = err_q;

  // Command latch, transfer counters, write-back register and framing flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base_q <= '0;
      dst_base_q <= '0;
      src_len_q  <= '0;
      dst_len_q  <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else if (cmd_accept) begin
      src_base_q <= src_base;
      dst_base_q <= dst_base;
      src_len_q  <= src_len;
      dst_len_q  <= dst_len;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (mem_rd_en) rd_cnt_q <= rd_cnt_q + 12'd1;
      if (tx_pop)    tx_cnt_q <= tx_cnt_q + 12'd1;
      fifo_cnt_q <= fifo_cnt_q - 2'(fifo_pop) + 2'(fifo_push);
      wr_en_q    <= rx_acc;
      if (rx_acc) begin
        wr_addr_q <= dst_base_q + AW'(rx_cnt_q);
        wr_data_q <= dst_data;
        rx_cnt_q  <= rx_cnt_q + 12'd1;
        if (dst_last != rx_final) err_q <= 1'b1;
      end
    end
  end

  // Skid FIFO storage: shift on pop, then fill the first free slot
  always_ff @(posedge clk) begin
    if (fifo_pop) fifo0_q <= fifo1_q;
    if (fifo_push) begin
      if ((fifo_cnt_q - 2'(fifo_pop)) == 2'd0) fifo0_q <= mem_rd_data;
      else                                     fifo1_q <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dnn_stream_host.sv
// Bench for dnn_stream_host: buffer memory model, stream monitors and a
// reference model of what each command must move, where and when.
module tb_dnn_stream_host;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [11:0]   src_len, dst_len;
  logic          busy, done, err;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic          src_valid, src_last, src_ready;
  logic [DW-1:0] src_data;
  logic          dst_valid, dst_last, dst_ready;
  logic [DW-1:0] dst_data;

  always #5 clk = ~clk;

  dnn_stream_host #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_base(src_base), .src_len(src_len), .dst_base(dst_base), .dst_len(dst_len),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
  );

  typedef struct { logic [DW-1:0] d; logic l; int c; } sw_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;

  logic [DW-1:0] mem [0:65535];
  int  cyc = 0;
  int  t0 = 0;
  int  checks = 0, errors = 0;

  sw_t src_q[$];
  wr_t wr_q[$];
  int  done_q[$], rd_q[$], acc_q[$];
  int  n_issued = 0, n_acc = 0, viol_stab = 0, viol_out = 0;
  logic pv_stall = 1'b0;
  logic [DW-1:0] pv_d;
  logic pv_l;

  logic [DW-1:0] dv[$];
  logic          dlq[$];
  int b_src, b_wr, b_acc, b_done, b_rd;
  int r_done_rel, r_err_rise;
  logic r_err_done, r_err_first;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer memory read port: data one cycle after the strobe
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Stream and memory monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      n_issued = 0; n_acc = 0; pv_stall = 1'b0;
    end else begin
      if (pv_stall && !(src_valid === 1'b1 && src_data === pv_d && src_last === pv_l))
        viol_stab++;
      pv_stall = src_valid && !src_ready;
      pv_d = src_data; pv_l = src_last;
      if (mem_rd_en) begin rd_q.push_back(cyc - t0 + 1); n_issued++; end
      if (n_issued - n_acc > 2) viol_out++;
      if (src_valid && src_ready) begin
        src_q.push_back('{src_data, src_last, cyc - t0 + 1}); n_acc++;
      end
      if (mem_wr_en) wr_q.push_back('{mem_wr_addr, mem_wr_data, cyc - t0 + 1});
      if (done) done_q.push_back(cyc - t0 + 1);
      if (dst_valid && dst_ready) acc_q.push_back(cyc - t0 + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return busy | done | err | mem_rd_en | (|mem_rd_addr) | mem_wr_en | (|mem_wr_addr) |
           (|mem_wr_data) | src_valid | (|src_data) | src_last | dst_ready;
  endfunction

  function automatic logic ready_val(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[n % 6] != 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_dst(input int di, input int gap);
    if (di < dv.size() && $urandom_range(0, 99) >= gap) begin
      dst_valid = 1'b1; dst_data = dv[di]; dst_last = dlq[di];
    end else begin
      dst_valid = 1'b0; dst_data = '0; dst_last = 1'b0;
    end
  endtask

  // Issue one command and drive both streams until done (or abort by reset)
  task automatic run_cmd(input logic [AW-1:0] sb, input logic [11:0] sl,
                         input logic [AW-1:0] db, input logic [11:0] dlen,
                         input int mode, input int gap, input int abort_n, input bit extra);
    int di; bit acc; bit fin;
    b_src = src_q.size(); b_wr = wr_q.size(); b_acc = acc_q.size();
    b_done = done_q.size(); b_rd = rd_q.size();
    r_done_rel = -1; r_err_rise = -1; r_err_done = 1'bx; r_err_first = 1'bx;
    di = 0; fin = 0;
    @(posedge clk); #1;
    src_base = sb; src_len = sl; dst_base = db; dst_len = dlen; start = 1'b1;
    t0 = cyc + 1;
    src_ready = ready_val(mode, 0);
    drive_dst(di, gap);
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      acc = dst_valid && dst_ready;
      if (n == 1) r_err_first = err;
      if (n >= 1 && err && r_err_rise < 0) r_err_rise = cyc - t0 + 1;
      if (done) begin fin = 1; r_done_rel = cyc - t0 + 1; r_err_done = err; end
      @(posedge clk); #1;
      start = extra && (n == 1);
      if (start) begin src_base = 16'h0500; src_len = 12'd2; end
      if (acc) di++;
      drive_dst(di, gap);
      src_ready = ready_val(mode, n + 1);
      if (n == abort_n) begin
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_cmd_outputs", any_out(), 1'b0);
        dst_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        fin = 1;
      end
    end
    chk("cmd_completed", fin, 1'b1);
    dst_valid = 1'b0; start = 1'b0;
    if (abort_n < 0) begin
      @(negedge clk);
      chk("busy_done_after_completion", {busy, done}, 2'b00);
    end
  endtask

  // Reference model: expected stream contents, write-backs and framing flag
  task automatic verify(input string tg, input logic [AW-1:0] sb, input logic [11:0] sl,
                        input logic [AW-1:0] db, input logic [11:0] dlen);
    int got; logic [AW-1:0] a; bit eerr;
    got = src_q.size() - b_src;
    chk({tg, "_src_count"}, got, sl);
    for (int i = 0; i < got && i < int'(sl); i++) begin
      a = sb + AW'(i);
      chk({tg, "_src_data"}, src_q[b_src + i].d, mem[a]);
      chk({tg, "_src_last"}, src_q[b_src + i].l, (i == int'(sl) - 1));
    end
    chk({tg, "_dst_accepted"}, acc_q.size() - b_acc, dlen);
    got = wr_q.size() - b_wr;
    chk({tg, "_wr_count"}, got, dlen);
    for (int k = 0; k < got && k < int'(dlen); k++) begin
      a = db + AW'(k);
      chk({tg, "_wr_addr"}, wr_q[b_wr + k].a, a);
      chk({tg, "_wr_data"}, wr_q[b_wr + k].d, dv[k]);
      chk({tg, "_wr_timing"}, wr_q[b_wr + k].c, acc_q[b_acc + k] + 1);
    end
    eerr = 0;
    for (int k = 0; k < int'(dlen); k++) if (dlq[k] != (k == int'(dlen) - 1)) eerr = 1;
    chk({tg, "_err"}, r_err_done, eerr);
    chk({tg, "_done_pulses"}, done_q.size() - b_done, 1);
    chk({tg, "_src_stable_while_stalled"}, viol_stab, 0);
    chk({tg, "_outstanding_reads"}, viol_out, 0);
  endtask

  task automatic t1_timing(input string tg);
    chk({tg, "_first_read_cycle"}, (rd_q.size() > b_rd) ? rd_q[b_rd] : -1, 1);
    for (int i = 0; i < 4; i++)
      chk({tg, "_word_cycle"}, (src_q.size() > b_src + i) ? src_q[b_src + i].c : -1, 2 + i);
    chk({tg, "_done_cycle"}, r_done_rel, 6);
  endtask

  initial begin
    logic [11:0] sl, dl;
    logic [AW-1:0] sb, db;
    int noff;
    rst_n = 1'b0; start = 1'b0; src_base = '0; src_len = '0; dst_base = '0; dst_len = '0;
    src_ready = 1'b0; dst_valid = 1'b0; dst_data = '0; dst_last = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'(i + 1);

    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", any_out(), 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;

    // T1: four words at full rate
    dv.delete(); dlq.delete();
    run_cmd(16'h0010, 12'd4, 16'h0000, 12'd0, 0, 0, -1, 1'b0);
    verify("t1", 16'h0010, 12'd4, 16'h0000, 12'd0);
    t1_timing("t1");

    // T2: stalling consumer
    run_cmd(16'h0100, 12'd5, 16'h0000, 12'd0, 1, 0, -1, 1'b0);
    verify("t2", 16'h0100, 12'd5, 16'h0000, 12'd0);

    // T3: clean receive
    dv = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003}; dlq = '{1'b0, 1'b0, 1'b1};
    run_cmd(16'h0000, 12'd0, 16'h0040, 12'd3, 0, 0, -1, 1'b0);
    verify("t3", 16'h0000, 12'd0, 16'h0040, 12'd3);

    // T4: early dst_last raises err after the second word
    dv = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333}; dlq = '{1'b0, 1'b1, 1'b0};
    run_cmd(16'h0000, 12'd0, 16'h0080, 12'd3, 0, 0, -1, 1'b0);
    verify("t4", 16'h0000, 12'd0, 16'h0080, 12'd3);
    chk("t4_err_rise_cycle", r_err_rise, acc_q[b_acc + 1] + 1);

    // T4b: next start clears err; surplus dst words refused
    dv = '{32'h4444_0000, 32'h5555_0000, 32'h6666_0000, 32'h7777_0000};
    dlq = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_cmd(16'h0200, 12'd3, 16'h00C0, 12'd2, 0, 0, -1, 1'b0);
    chk("t4b_err_cleared_by_start", r_err_first, 1'b0);
    verify("t4b", 16'h0200, 12'd3, 16'h00C0, 12'd2);

    // T5: start while busy is ignored; zero-length command
    dv.delete(); dlq.delete();
    run_cmd(16'h0300, 12'd6, 16'h0000, 12'd0, 0, 0, -1, 1'b1);
    verify("t5_busy", 16'h0300, 12'd6, 16'h0000, 12'd0);
    run_cmd(16'h0000, 12'd0, 16'h0000, 12'd0, 0, 0, -1, 1'b0);
    verify("t5_zero", 16'h0000, 12'd0, 16'h0000, 12'd0);
    chk("t5_zero_done_cycle", r_done_rel, 1);

    // T6: reset mid-T1, then T1 again
    run_cmd(16'h0010, 12'd4, 16'h0000, 12'd0, 0, 0, 2, 1'b0);
    chk("t6_no_done_after_abort", done_q.size() - b_done, 0);
    run_cmd(16'h0010, 12'd4, 16'h0000, 12'd0, 0, 0, -1, 1'b0);
    verify("t6", 16'h0010, 12'd4, 16'h0000, 12'd0);
    t1_timing("t6");

    // Randomized concurrent commands, address wrap and framing faults
    for (int r = 0; r < 10; r++) begin
      sl = 12'($urandom_range(0, 12));
      dl = 12'($urandom_range(0, 12));
      sb = (r == 3) ? 16'hFFFC : AW'($urandom_range(0, 16'h7FFF));
      db = (r == 5) ? 16'hFFFE : AW'(16'h8000 + $urandom_range(0, 16'h7FF0));
      dv.delete(); dlq.delete();
      noff = int'(dl) + $urandom_range(0, 2);
      for (int k = 0; k < noff; k++) begin
        dv.push_back($urandom);
        dlq.push_back(k == int'(dl) - 1);
      end
      if (dl != 0 && $urandom_range(0, 3) == 0) begin
        noff = $urandom_range(0, int'(dl) - 1);
        dlq[noff] = ~dlq[noff];
      end
      run_cmd(sb, sl, db, dl, 2, 30, -1, 1'b0);
      verify("rand", sb, sl, db, dl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
